instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting directly upstream of the synchronous program memory. It drives the memory's 8-bit byte address and consumes the returned byte one cycle later. It assembles byte pairs into 16-bit instructions and buffers them in a 2-entry queue for the decoder behind a valid/ready handshake. It also handles branch redirects (flush), halt, and PC wrap-around.

## Interface
- RESET_PC, 8'h00, byte address fetched first after reset; bit 0 treated as 0.
- FIFO_DEPTH, 2, instruction buffer entries; only 2 is supported.

- Clock  input  1  single clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high.
- Address  output  8  program memory byte address; registered.
- Data  input  8  program memory read data; valid the cycle after its Address was presented.
- Instr  output  16  head instruction: {byte at even addr, byte at even addr+1}.
- InstrPC  output  8  even byte address of Instr.
- InstrValid  output  1  buffer non-empty.
- InstrReady  input  1  decoder accepts head when InstrValid && InstrReady.
- Branch  input  1  single-cycle redirect request.
- BranchTarget  input  8  redirect address; bit 0 ignored.
- Halt  input  1  level; stops starting new instructions.

## Operation
- State:
  - FetchPC (drives Address).
  - Phase: EVEN/ODD, the next byte to request.
  - InFlight flag plus address bit 0 of the byte requested last cycle.
  - HiByte/HiValid.
  - Assembling: set on even-byte issue, cleared on the instruction push.
  - 2-entry FIFO of {instr, pc}.
- Reset: Address=RESET_PC, Phase=EVEN, InFlight=0, HiValid=0, Assembling=0, FIFO empty, InstrValid=0, Instr=16'h0000, InstrPC=8'h00.
- Issue, EVEN phase:
  - Allowed iff !Halt && (fifo_count + Assembling) < 2, using registered values; a pop in the same cycle does not free a slot until the next cycle.
  - On issue: FetchPC+1, Phase=ODD, Assembling=1, InFlight=1.
  - Otherwise Address holds and InFlight=0.
- Issue, ODD phase: always issues (Halt ignored), then FetchPC+1, Phase=EVEN, InFlight=1.
- Return:
  - InFlight with even address: Data latched into HiByte, HiValid=1.
  - InFlight with odd address: push {HiByte, Data}, pc=FetchPC_of_even; clear HiValid and Assembling.
- Pop: InstrValid && InstrReady removes the head. Push and pop in the same cycle are both performed.
- FetchPC arithmetic: 8-bit, wraps 8'hFF→8'h00; the pair at 8'hFE/8'hFF is followed by 8'h00.
- Branch (priority below Reset, above everything else):
  - Flush the FIFO; discard HiByte, the Assembling state and the in-flight byte.
  - FetchPC={BranchTarget[7:1],1'b0}, Phase=EVEN.
  - A pop asserted in the Branch cycle is still counted as accepted; no entry is valid the next cycle.
- Halt: an in-progress pair completes and is pushed; the FIFO keeps draining. Fetch resumes at the next even address when Halt drops.

## Timing
- Throughput: at most one instruction per 2 cycles.
- Latency from Reset low (cycle 0, Address=RESET_PC):
  - cycle 1: Address=+1, Data=byte0.
  - cycle 2: Data=byte1.
  - cycle 3: InstrValid=1.
- Branch asserted in cycle b:
  - Address=target in cycle b+1.
  - First new instruction valid in cycle b+4.
  - InstrValid=0 in cycles b+1..b+3.
- Instr/InstrPC are don't-care while InstrValid=0 (except at reset).
- Reset asserted mid-operation returns to the reset state on the next edge. It overrides Branch and Halt, and in-flight data is discarded.

## Structure
- Package fetch_pkg: INSTR_W=16, PC_W=8, FIFO_DEPTH=2, typedef struct packed {logic [15:0] instr; logic [7:0] pc;} fetch_entry_t.
- Sub-module instr_fifo: 2-entry synchronous FIFO of fetch_entry_t with push/pop/flush, count[1:0], head output, Reset-cleared.

## Test plan
Program memory image: 00:12 01:34 02:56 03:78 04:9A 05:BC; 40:AA 41:BB; FE:CA FF:FE.
- Reset, then InstrReady=1 → InstrValid in cycle 3 with 16'h1234/PC 00; 16'h5678/PC 02 in cycle 5; 16'h9ABC/PC 04 in cycle 7.
- InstrReady=0 for 12 cycles → FIFO holds 1234, 5678; Address stops at 8'h04 with no further issue. Release → 1234, 5678, 9ABC in order, no loss or duplicate.
- Branch=1, BranchTarget=8'h41 in cycle 4 with InstrReady=1 → no old-stream instruction after cycle 4; 16'hAABB/PC 40 valid in cycle 8.
- Branch to 8'hFE → 16'hCAFE/PC FE, then 16'h1234/PC 00 (wrap).
- Halt=1 in cycle 1 (even byte 00 already issued) → 16'h1234 still delivered, Address holds at 8'h02. Halt=0 → 16'h5678 follows.
- Reset=1 mid-stream with a byte in flight → next cycle InstrValid=0 and Address=RESET_PC; after release, the stream restarts at 16'h1234 with cycle-3 latency.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INSTR_W    = 16;
    localparam int PC_W       = 8;
    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    typedef enum logic {
        PHASE_EVEN = 1'b0,
        PHASE_ODD  = 1'b1
    } fetch_phase_t;

    // Instructions always start on an even byte, so bit 0 of any
    // externally supplied address is forced low.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return addr & {{(PC_W-1){1'b1}}, 1'b0};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Two-entry instruction buffer between fetch and decode, with flush on redirect.
module instr_fifo
    import fetch_pkg::*;
(
    input  logic         Clock,
    input  logic         Reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'(FIFO_DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; flush drops every entry but keeps stale data.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: walks the byte-wide program memory, pairs bytes into
// 16-bit instructions and hands them to the decoder through a small buffer.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [PC_W-1:0]    Address,
    input  logic [7:0]         Data,
    output logic [INSTR_W-1:0] Instr,
    output logic [PC_W-1:0]    InstrPC,
    output logic               InstrValid,
    input  logic               InstrReady,
    input  logic               Branch,
    input  logic [PC_W-1:0]    BranchTarget,
    input  logic               Halt
);

    logic [PC_W-1:0] fetch_pc,      fetch_pc_nxt;
    fetch_phase_t    phase,         phase_nxt;
    logic            in_flight,     in_flight_nxt;
    logic            in_flight_odd, in_flight_odd_nxt;
    logic [7:0]      hi_byte,       hi_byte_nxt;
    logic            hi_valid,      hi_valid_nxt;
    logic            assembling,    assembling_nxt;
    logic [PC_W-1:0] even_pc,       even_pc_nxt;

    logic            fifo_push;
    logic            fifo_pop;
    fetch_entry_t    fifo_in;
    fetch_entry_t    fifo_head;
    logic [1:0]      fifo_count;
    logic            even_issue_ok;

    // A new pair may start only if it is guaranteed a buffer slot; slots
    // freed by a pop this cycle are not visible until the next cycle.
    assign even_issue_ok = !Halt &&
                           (({1'b0, fifo_count} + {2'b00, assembling}) < 3'(FIFO_DEPTH));

    // The odd byte returning completes the pair; a redirect discards it.
    assign fifo_push = in_flight && in_flight_odd && hi_valid && !Branch;
    assign fifo_pop  = InstrValid && InstrReady;
    assign fifo_in   = '{instr: {hi_byte, Data}, pc: even_pc};

    assign Address    = fetch_pc;
    assign InstrValid = (fifo_count != 2'd0);
    assign Instr      = fifo_head.instr;
    assign InstrPC    = fifo_head.pc;

    instr_fifo u_fifo (
        .Clock      (Clock),
        .Reset      (Reset),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .flush      (Branch),
        .push_entry (fifo_in),
        .head       (fifo_head),
        .count      (fifo_count)
    );

    // Next-state logic: returning byte handling, byte issue, then redirect override.
    always_comb begin
        fetch_pc_nxt      = fetch_pc;
        phase_nxt         = phase;
        in_flight_nxt     = 1'b0;
        in_flight_odd_nxt = in_flight_odd;
        hi_byte_nxt       = hi_byte;
        hi_valid_nxt      = hi_valid;
        assembling_nxt    = assembling;
        even_pc_nxt       = even_pc;

        if (in_flight && !in_flight_odd) begin
            hi_byte_nxt  = Data;
            hi_valid_nxt = 1'b1;
        end
        if (fifo_push) begin
            hi_valid_nxt   = 1'b0;
            assembling_nxt = 1'b0;
        end

        case (phase)
            PHASE_EVEN: begin
                if (even_issue_ok) begin
                    even_pc_nxt       = fetch_pc;
                    fetch_pc_nxt      = fetch_pc + PC_W'(1);
                    phase_nxt         = PHASE_ODD;
                    assembling_nxt    = 1'b1;
                    in_flight_nxt     = 1'b1;
                    in_flight_odd_nxt = fetch_pc[0];
                end
            end
            PHASE_ODD: begin
                fetch_pc_nxt      = fetch_pc + PC_W'(1);
                phase_nxt         = PHASE_EVEN;
                in_flight_nxt     = 1'b1;
                in_flight_odd_nxt = fetch_pc[0];
            end
            default: begin
                phase_nxt = PHASE_EVEN;
            end
        endcase

        if (Branch) begin
            fetch_pc_nxt   = align_pc(BranchTarget);
            phase_nxt      = PHASE_EVEN;
            in_flight_nxt  = 1'b0;
            hi_valid_nxt   = 1'b0;
            assembling_nxt = 1'b0;
        end
    end

    // State register with synchronous reset back to the start address.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fetch_pc      <= align_pc(RESET_PC);
            phase         <= PHASE_EVEN;
            in_flight     <= 1'b0;
            in_flight_odd <= 1'b0;
            hi_byte       <= 8'h00;
            hi_valid      <= 1'b0;
            assembling    <= 1'b0;
            even_pc       <= '0;
        end else begin
            fetch_pc      <= fetch_pc_nxt;
            phase         <= phase_nxt;
            in_flight     <= in_flight_nxt;
            in_flight_odd <= in_flight_odd_nxt;
            hi_byte       <= hi_byte_nxt;
            hi_valid      <= hi_valid_nxt;
            assembling    <= assembling_nxt;
            even_pc       <= even_pc_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed timing checks plus a randomized run
// compared against an in-order instruction stream model.
module tb_instr_fetch;

    logic        Clock;
    logic        Reset;
    logic [7:0]  Address;
    logic [7:0]  Data;
    logic [15:0] Instr;
    logic [7:0]  InstrPC;
    logic        InstrValid;
    logic        InstrReady;
    logic        Branch;
    logic [7:0]  BranchTarget;
    logic        Halt;

    logic [7:0]  pmem [256];
    logic [7:0]  exp_pc;
    int          gap;
    int          tests_run;
    int          tests_failed;

    instr_fetch #(.RESET_PC(8'h00)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Address      (Address),
        .Data         (Data),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .Branch       (Branch),
        .BranchTarget (BranchTarget),
        .Halt         (Halt)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Synchronous program memory: data for an address appears one cycle later.
    always @(posedge Clock) begin
        Data <= pmem[Address];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic applyReset();
        Reset      = 1'b1;
        Branch     = 1'b0;
        Halt       = 1'b0;
        InstrReady = 1'b1;
        nextCycle();
        nextCycle();
        Reset = 1'b0;
    endtask

    task automatic waitValid(input string name, input int limit);
        int n = 0;
        while (InstrValid !== 1'b1 && n < limit) begin
            nextCycle();
            n++;
        end
        tests_run++;
        if (InstrValid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s: no valid instruction within %0d cycles", name, limit);
        end
    endtask

    task automatic applyStimulus();
        InstrReady   = ($urandom_range(0, 9) < 7);
        Branch       = ($urandom_range(0, 99) < 3);
        BranchTarget = 8'($urandom);
        if ($urandom_range(0, 99) < 5) Halt = !Halt;
        Reset        = ($urandom_range(0, 299) == 0);
    endtask

    // Stream model: the decoder must see consecutive even-address pairs from
    // the last reset/redirect point, and gaps must stay short when not halted.
    always @(negedge Clock) begin
        if (InstrValid === 1'b1) begin
            checkOutput("stream", {8'h00, Instr, InstrPC},
                        {8'h00, pmem[exp_pc], pmem[exp_pc + 8'd1], exp_pc});
            if (gap > 0) begin
                tests_run++;
                if (gap > 4) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_gap: gap of %0d cycles, limit 4", gap);
                end
                gap = 0;
            end
            if (InstrReady === 1'b1) exp_pc = exp_pc + 8'd2;
        end
        if (Reset === 1'b1 || Branch === 1'b1 || Halt === 1'b1) gap = 0;
        else if (InstrValid !== 1'b1) gap++;
        if (Branch === 1'b1) exp_pc = BranchTarget & 8'hFE;
        if (Reset === 1'b1) exp_pc = 8'h00;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_pc       = 8'h00;
        gap          = 0;
        Reset        = 1'b1;
        Branch       = 1'b0;
        BranchTarget = 8'h00;
        Halt         = 1'b0;
        InstrReady   = 1'b0;
        for (int i = 0; i < 256; i++) pmem[i] = 8'($urandom);
        pmem[8'h00] = 8'h12; pmem[8'h01] = 8'h34; pmem[8'h02] = 8'h56;
        pmem[8'h03] = 8'h78; pmem[8'h04] = 8'h9A; pmem[8'h05] = 8'hBC;
        pmem[8'h40] = 8'hAA; pmem[8'h41] = 8'hBB;
        pmem[8'hFE] = 8'hCA; pmem[8'hFF] = 8'hFE;

        // Reset values and first-instruction latency
        Reset = 1'b1; nextCycle(); nextCycle();
        checkOutput("rst_valid", 32'(InstrValid), 32'h0);
        checkOutput("rst_instr", 32'(Instr), 32'h0);
        checkOutput("rst_pc", 32'(InstrPC), 32'h0);
        checkOutput("rst_addr", 32'(Address), 32'h0);
        applyReset();
        checkOutput("c0_addr", 32'(Address), 32'h00);
        nextCycle();
        checkOutput("c1_addr", 32'(Address), 32'h01);
        nextCycle();
        checkOutput("c2_valid", 32'(InstrValid), 32'h0);
        nextCycle();
        checkOutput("c3_instr", {InstrValid, 7'h0, Instr, InstrPC}, {1'b1, 7'h0, 16'h1234, 8'h00});
        nextCycle(); nextCycle();
        checkOutput("c5_instr", {InstrValid, 7'h0, Instr, InstrPC}, {1'b1, 7'h0, 16'h5678, 8'h02});
        nextCycle(); nextCycle();
        checkOutput("c7_instr", {InstrValid, 7'h0, Instr, InstrPC}, {1'b1, 7'h0, 16'h9ABC, 8'h04});

        // Decoder backpressure: buffer fills and fetch stops
        applyReset();
        InstrReady = 1'b0;
        repeat (6) nextCycle();
        checkOutput("stall_addr6", 32'(Address), 32'h04);
        repeat (6) nextCycle();
        checkOutput("stall_addr12", 32'(Address), 32'h04);
        checkOutput("stall_head", {InstrValid, 7'h0, Instr, InstrPC}, {1'b1, 7'h0, 16'h1234, 8'h00});
        InstrReady = 1'b1;
        nextCycle();
        checkOutput("stall_next", {InstrValid, 7'h0, Instr, InstrPC}, {1'b1, 7'h0, 16'h5678, 8'h02});
        nextCycle();
        waitValid("stall_third", 8);
        checkOutput("stall_third", 32'(Instr), 32'h9ABC);

        // Redirect in cycle 4 to an odd target
        applyReset();
        repeat (4) nextCycle();
        Branch = 1'b1; BranchTarget = 8'h41;
        nextCycle();
        Branch = 1'b0;
        checkOutput("br_addr", 32'(Address), 32'h40);
        checkOutput("br_b1_valid", 32'(InstrValid), 32'h0);
        nextCycle();
        checkOutput("br_b2_valid", 32'(InstrValid), 32'h0);
        nextCycle();
        checkOutput("br_b3_valid", 32'(InstrValid), 32'h0);
        nextCycle();
        checkOutput("br_b4_instr", {InstrValid, 7'h0, Instr, InstrPC}, {1'b1, 7'h0, 16'hAABB, 8'h40});

        // Redirect to the top of memory with a pop in the same cycle, then wrap
        Branch = 1'b1; BranchTarget = 8'hFF;
        nextCycle();
        Branch = 1'b0;
        checkOutput("wrap_flush", 32'(InstrValid), 32'h0);
        waitValid("wrap_first", 8);
        checkOutput("wrap_first", {Instr, InstrPC}, {16'hCAFE, 8'hFE});
        nextCycle();
        waitValid("wrap_second", 8);
        checkOutput("wrap_second", {Instr, InstrPC}, {16'h1234, 8'h00});
        nextCycle();
        checkOutput("model_wrap", 32'(exp_pc), 32'h02);

        // Halt after the even byte went out: pair completes, fetch parks
        applyReset();
        nextCycle();
        Halt = 1'b1;
        nextCycle(); nextCycle();
        checkOutput("halt_instr", {InstrValid, 7'h0, Instr, InstrPC}, {1'b1, 7'h0, 16'h1234, 8'h00});
        checkOutput("halt_addr3", 32'(Address), 32'h02);
        repeat (3) nextCycle();
        checkOutput("halt_addr6", 32'(Address), 32'h02);
        checkOutput("halt_valid6", 32'(InstrValid), 32'h0);
        nextCycle();
        Halt = 1'b0;
        repeat (3) nextCycle();
        checkOutput("halt_resume", {InstrValid, 7'h0, Instr, InstrPC}, {1'b1, 7'h0, 16'h5678, 8'h02});

        // Reset mid-stream with a byte in flight
        applyReset();
        repeat (5) nextCycle();
        Reset = 1'b1;
        nextCycle();
        checkOutput("mrst_state", {InstrValid, 7'h0, Instr, InstrPC}, 32'h0);
        checkOutput("mrst_addr", 32'(Address), 32'h00);
        Reset = 1'b0;
        nextCycle(); nextCycle();
        checkOutput("mrst_c2_valid", 32'(InstrValid), 32'h0);
        nextCycle();
        checkOutput("mrst_c3_instr", {InstrValid, 7'h0, Instr, InstrPC}, {1'b1, 7'h0, 16'h1234, 8'h00});

        // Randomized traffic against the stream model
        repeat (3000) begin
            applyStimulus();
            nextCycle();
        end
        Reset = 1'b0; Branch = 1'b0; Halt = 1'b0; InstrReady = 1'b1;
        repeat (20) nextCycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
